// File: rtl/psum_rf_drain_ctrl_if.sv
// Global-buffer write port: valid/ready handshake carrying one psum word and its address.
interface psum_rf_drain_ctrl_if #(
  parameter int unsigned DATA_BITWIDTH    = 16,
  parameter int unsigned GB_ADDR_BITWIDTH = 10
);
  logic                        valid;
  logic                        ready;
  logic [DATA_BITWIDTH-1:0]    data;
  logic [GB_ADDR_BITWIDTH-1:0] addr;

  modport master (output valid, output data, output addr, input ready);
  modport slave  (input valid, input data, input addr, output ready);
endinterface

// File: rtl/psum_rf_drain_ctrl.sv
// psum_rf_drain_ctrl: on every en1 swap, sweeps the now-inactive psum RF bank and streams each
// word to the global buffer at base + word index through a 2-entry skid FIFO.
module psum_rf_drain_ctrl #(
  parameter int unsigned DATA_BITWIDTH    = 16,
  parameter int unsigned ADDR_BITWIDTH    = 2,
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned GB_ADDR_BITWIDTH = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en1,
  input  logic [DATA_BITWIDTH-1:0]    out1,
  input  logic [DATA_BITWIDTH-1:0]    out2,
  input  logic                        base_load,
  input  logic [GB_ADDR_BITWIDTH-1:0] base_value,
  output logic [ADDR_BITWIDTH-1:0]    addr_from_su_adder,
  psum_rf_drain_ctrl_if.master        gb,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun
);

  localparam logic [ADDR_BITWIDTH-1:0]    LastIdx  = ADDR_BITWIDTH'(DEPTH - 1);
  localparam logic [GB_ADDR_BITWIDTH-1:0] DepthInc = GB_ADDR_BITWIDTH'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StFlush} state_e;

  state_e                      state_q;
  logic                        en1_q;
  logic                        bank_sel_q;
  logic [ADDR_BITWIDTH-1:0]    idx_q;
  logic                        inflight_q;
  logic [GB_ADDR_BITWIDTH-1:0] inflight_addr_q;
  logic [GB_ADDR_BITWIDTH-1:0] base_q;
  logic [DATA_BITWIDTH-1:0]    fifo_data_q [2];
  logic [GB_ADDR_BITWIDTH-1:0] fifo_addr_q [2];
  logic                        rd_ptr_q;
  logic                        wr_ptr_q;
  logic [1:0]                  count_q;
  logic                        done_q;
  logic                        overrun_q;

  logic                     swap;
  logic                     pop;
  logic                     push;
  logic                     issue;
  logic                     flush_done;
  logic [1:0]               count_d;
  logic [DATA_BITWIDTH-1:0] rd_data;

  // Handshake decode, read-issue credit and drain-completion detect
  always_comb begin
    swap    = en1 ^ en1_q;
    pop     = (count_q != 2'd0) && gb.ready;
    push    = inflight_q;
    // A slot freed by this cycle's pop may be refilled by a read issued now: 1 word/cycle
    issue   = (state_q == StIssue) &&
              (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    // Last word leaves the FIFO this cycle with nothing left to arrive
    flush_done = (state_q == StFlush) && !inflight_q && (count_d == 2'd0);
    rd_data = bank_sel_q ? out2 : out1;
  end

  // Swap detect, drain FSM, read issue, FIFO and base-address bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      en1_q           <= en1;
      bank_sel_q      <= 1'b0;
      idx_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      base_q          <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      done_q          <= 1'b0;
      overrun_q       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
    end else begin
      en1_q  <= en1;
      done_q <= 1'b0;
      if (swap) begin
        // A swap (re)starts a drain of the new inactive bank; anything pending is dropped
        if (state_q != StIdle) begin
          overrun_q <= 1'b1;
        end else if (base_load) begin
          base_q <= base_value;
        end
        state_q    <= StIssue;
        bank_sel_q <= en1;
        idx_q      <= '0;
        inflight_q <= 1'b0;
        count_q    <= 2'd0;
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
      end else begin
        if (push) begin
          fifo_data_q[wr_ptr_q] <= rd_data;
          fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
          wr_ptr_q              <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        count_q    <= count_d;
        inflight_q <= issue;
        if (issue) begin
          inflight_addr_q <= base_q + GB_ADDR_BITWIDTH'(idx_q);
          idx_q           <= idx_q + ADDR_BITWIDTH'(1);
        end
        unique case (state_q)
          StIdle: begin
            if (base_load) begin
              base_q <= base_value;
            end
          end
          StIssue: begin
            if (issue && (idx_q == LastIdx)) begin
              state_q <= StFlush;
            end
          end
          StFlush: begin
            if (flush_done) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
              base_q  <= base_load ? base_value : base_q + DepthInc;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign addr_from_su_adder = idx_q;
  assign gb.valid           = (count_q != 2'd0);
  assign gb.data            = fifo_data_q[rd_ptr_q];
  assign gb.addr            = fifo_addr_q[rd_ptr_q];
  assign busy               = (state_q != StIdle);
  assign done               = done_q;
  assign overrun            = overrun_q;

endmodule
